// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one shared 1-bit full adder walks the operands
// LSB first over WIDTH cycles, then holds the result until acknowledged.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b, res_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             fa_h, fa_s, fa_c, last;

  // Full adder as two half-adder XOR stages plus carry merge
  assign fa_h = op_a[0] ^ op_b[0];
  assign fa_s = fa_h ^ carry_q;
  assign fa_c = (op_a[0] & op_b[0]) | (fa_h & carry_q);
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_a    <= a;
          op_b    <= sub ? ~b : b;
          carry_q <= sub;
          res_q   <= '0;
          cnt_q   <= '0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        RUN: begin
          carry_q <= fa_c;
          op_a    <= op_a >> 1;
          op_b    <= op_b >> 1;
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          if (last) begin
            // carry_q here is the carry into the MSB, fa_c the carry out of it
            sum_q  <= {fa_s, res_q[WIDTH-1:1]};
            cout_q <= fa_c;
            ovf_q  <= carry_q ^ fa_c;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed table, corner
// sequences, and random operations against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, ack;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ack(ack), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] x, y, es;
    logic         ec, ev;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow
  task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic v);
    int unsigned t;
    int sx, sy, sr;
    logic [W-1:0] ny;
    ny = ~y;
    t  = s ? (32'(x) + 32'(ny) + 1) : (32'(x) + 32'(y));
    r  = t[W-1:0];
    c  = t[W];
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = s ? sx - sy : sx + sy;
    v  = (sr > 127) || (sr < -128);
  endtask

  // Called right after a negedge; returns after ack is taken.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] es,
                        input logic ec, input logic ev);
    int n;
    sub = s; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); sub = ~s;
    chk({tag, " busy@run"}, 32'(busy), 1);
    chk({tag, " sum0@run"}, 32'(sum), 0);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_cycles"}, n, W);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf), 32'(ev));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, " done_clr"}, 32'(done), 0);
    chk({tag, " sum_kept"}, 32'(sum), 32'(es));
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c, v;
    int           n;

    tbl[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; ack = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst sum", 32'(sum), 0);
    chk("rst cout", 32'(cout), 0);
    chk("rst ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].es, tbl[i].ec, tbl[i].ev);

    // ack in IDLE is inert; previous result (0xFE,cout=1) retained
    ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    chk("idle_ack busy", 32'(busy), 0);
    chk("idle_ack sum", 32'(sum), 32'h0FE);
    chk("idle_ack cout", 32'(cout), 1);

    // Reset in IDLE clears a held result
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_rst sum", 32'(sum), 0);
    chk("idle_rst cout", 32'(cout), 0);

    // start pulses during RUN and DONE are ignored
    sub = 1'b0; a = 8'h3C; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("inj busy_cycles", n, W);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("inj done_hold", 32'(done), 1);
    chk("inj sum", 32'(sum), 32'h4B);
    // ack held low for 20 cycles
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b1 || sum !== 8'h4B) n++;
    end
    chk("hold20 glitches", n, 0);
    // start together with ack: ack wins, no new op
    start = 1'b1; ack = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    chk("ackstart done", 32'(done), 0);
    chk("ackstart busy", 32'(busy), 0);
    @(negedge clk);
    chk("ackstart idle", 32'(busy), 0);
    chk("ackstart sum", 32'(sum), 32'h4B);

    // Reset in the 4th RUN cycle abandons the op
    sub = 1'b0; a = 8'h3C; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst sum", 32'(sum), 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("midrst quiet", n, 0);
    run_op("post_rst", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);

    // Random operations against the model
    for (int i = 0; i < 30; i++) begin
      logic         rs;
      logic [W-1:0] rx, ry;
      rs = 1'($urandom);
      rx = W'($urandom);
      ry = W'($urandom);
      model(rs, rx, ry, r, c, v);
      run_op($sformatf("rnd%0d", i), rs, rx, ry, r, c, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH)+1, bit-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low; one clock, synchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 sub  input  1  operation select, sampled with start: 0 = a+b, 1 = a-b.
REQ-007 a  input  WIDTH  first operand, sampled with start.
REQ-008 b  input  WIDTH  second operand, sampled with start.
REQ-009 ack  input  1  consumer acknowledge of result; sampled only in DONE.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE; result valid.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  final carry out (sub: 1 = no borrow).
REQ-014 ovf  output  1  signed overflow of the result.

Function
REQ-015 Block SHALL sequence one shared 1-bit full-add datapath (two half-adder XOR stages plus carry merge) over WIDTH cycles, LSB first.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-017 IDLE: start=1 at edge k -> load A=a, B=(sub ? ~b : b), carry=sub, result shift register=0, counter=0, state RUN at edge k.
REQ-018 IDLE with start=0 SHALL remain IDLE, outputs unchanged.
REQ-019 RUN: each edge SHALL compute s=A[0]^B[0]^carry, carry<=majority(A[0],B[0],carry), shift A,B right by one, shift s into result MSB, counter+1.
REQ-020 On the edge where counter reaches WIDTH-1 (the WIDTH-th RUN edge, k+WIDTH), state SHALL go to DONE; busy high for exactly WIDTH cycles.
REQ-021 On entering DONE, sum SHALL equal (a + b) or (a - b) mod 2^WIDTH; cout = final carry; ovf = carry-in XOR carry-out of MSB position.
REQ-022 start SHALL be ignored in RUN and DONE; operands not resampled.
REQ-023 DONE: sum, cout, ovf, done SHALL hold stable until ack=1 sampled; then IDLE next edge, done low.
REQ-024 start and ack both high in DONE: ack honoured, start ignored; new op requires start in IDLE.
REQ-025 sum, cout, ovf SHALL retain last result in IDLE until next start, then read 0 during RUN.
REQ-026 ack in IDLE or RUN SHALL have no effect.
REQ-027 Operands a=0,b=0 and all-ones SHALL be handled with no special case; counter SHALL not wrap past WIDTH-1.

Reset
REQ-028 rst_n=0 sampled on an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, regardless of state.
REQ-029 Reset mid-RUN SHALL abandon operation; no done pulse; first start after rst_n=1 SHALL behave as from power-up.
REQ-030 rst_n has priority over start and ack in the same cycle.

Verification (WIDTH=8)
REQ-031 start, a=0x3C, b=0x0F, sub=0 -> busy 8 cycles, done at k+8, sum=0x4B, cout=0, ovf=0.
REQ-032 a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, ovf=1.
REQ-033 a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
REQ-034 start pulsed with new operands during RUN and during DONE -> ignored; result of first op unchanged.
REQ-035 ack held low 20 cycles in DONE -> done, sum held; ack=1 -> IDLE next edge, done=0.
REQ-036 rst_n=0 at 4th RUN cycle -> next edge all outputs 0, IDLE; subsequent op correct.
